// File: rtl/lights_decoder.sv
// Observer/decoder for the six-lamp tail-light sweep: tracks each half's phase,
// flags illegal patterns/transitions, counts sweeps. Optional: LIGHTS_DECODER_ERRCNT_EN.
module lights_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             la,
  input  logic             lb,
  input  logic             lc,
  input  logic             ra,
  input  logic             rb,
  input  logic             rc,
  output logic             left_on,
  output logic             right_on,
  output logic             left_done,
  output logic             right_done,
  output logic             err_l,
  output logic             err_r,
  output logic [CNT_W-1:0] left_sweeps,
  output logic [CNT_W-1:0] right_sweeps
`ifdef LIGHTS_DECODER_ERRCNT_EN
  ,
  output logic [CNT_W-1:0] err_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P1   = 2'd1,
    P2   = 2'd2,
    P3   = 2'd3
  } phase_t;

  typedef struct packed {
    phase_t next;
    logic   err;
    logic   done;
  } verdict_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  phase_t   q_l, q_r;
  verdict_t v_l, v_r;

  // Judge one half: the IDLE->P1 start is only legal while both halves are idle.
  function automatic verdict_t judge(input phase_t q, input phase_t other, input logic [2:0] p);
    verdict_t v;
    phase_t   pn;
    logic     enc_ok;
    logic     legal;
    enc_ok = 1'b1;
    pn     = IDLE;
    legal  = 1'b0;
    case (p)
      3'b000:  pn = IDLE;
      3'b100:  pn = P1;
      3'b110:  pn = P2;
      3'b111:  pn = P3;
      default: enc_ok = 1'b0;
    endcase
    case (q)
      IDLE:    legal = (pn == IDLE) || ((pn == P1) && (other == IDLE));
      P1:      legal = (pn == P2);
      P2:      legal = (pn == P3);
      P3:      legal = (pn == IDLE);
      default: legal = 1'b0;
    endcase
    v.next = enc_ok ? pn : IDLE;
    v.err  = !(enc_ok && legal);
    v.done = enc_ok && legal && (q == P3) && (pn == IDLE);
    return v;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + (CNT_W+1)'(inc);
    if (sum > {1'b0, CNT_MAX}) begin
      return CNT_MAX;
    end
    return sum[CNT_W-1:0];
  endfunction

  always_comb begin
    v_l = '0;
    v_r = '0;
    v_l = judge(q_l, q_r, {la, lb, lc});
    v_r = judge(q_r, q_l, {ra, rb, rc});
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_l          <= IDLE;
      q_r          <= IDLE;
      left_done    <= 1'b0;
      right_done   <= 1'b0;
      err_l        <= 1'b0;
      err_r        <= 1'b0;
      left_sweeps  <= '0;
      right_sweeps <= '0;
    end else begin
      q_l          <= v_l.next;
      q_r          <= v_r.next;
      left_done    <= v_l.done;
      right_done   <= v_r.done;
      err_l        <= v_l.err;
      err_r        <= v_r.err;
      left_sweeps  <= sat_add(left_sweeps, {1'b0, v_l.done});
      right_sweeps <= sat_add(right_sweeps, {1'b0, v_r.done});
    end
  end

`ifdef LIGHTS_DECODER_ERRCNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else begin
      err_count <= sat_add(err_count, {1'b0, v_l.err} + {1'b0, v_r.err});
    end
  end
`endif

  assign left_on  = (q_l != IDLE);
  assign right_on = (q_r != IDLE);

endmodule

// File: tb/tb_lights_decoder.sv
// Self-checking bench for lights_decoder: directed sequences plus randomized
// lamp patterns compared against a step-count model of the sweep rules.
module tb_lights_decoder;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             la, lb, lc, ra, rb, rc;
  logic             left_on, right_on, left_done, right_done, err_l, err_r;
  logic [CNT_W-1:0] left_sweeps, right_sweeps;
`ifdef LIGHTS_DECODER_ERRCNT_EN
  logic [CNT_W-1:0] err_count;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Model: number of lit lamps per half (0..3), sweep counts, expected pulses.
  int m_sl, m_sr, m_cl, m_cr, m_ec;
  bit m_dl, m_dr, m_el, m_er;

  lights_decoder #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .la           (la),
    .lb           (lb),
    .lc           (lc),
    .ra           (ra),
    .rb           (rb),
    .rc           (rc),
    .left_on      (left_on),
    .right_on     (right_on),
    .left_done    (left_done),
    .right_done   (right_done),
    .err_l        (err_l),
    .err_r        (err_r),
    .left_sweeps  (left_sweeps),
    .right_sweeps (right_sweeps)
`ifdef LIGHTS_DECODER_ERRCNT_EN
    ,
    .err_count    (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Lit-lamp count of a legal pattern, -1 for an illegal one.
  function automatic int steps(input logic [2:0] p);
    case (p)
      3'b000:  return 0;
      3'b100:  return 1;
      3'b110:  return 2;
      3'b111:  return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit isLegal(input int s, input int n, input int other);
    if (n < 0) return 0;
    if (s == 0) return (n == 0) || (n == 1 && other == 0);
    return n == (s + 1) % 4;
  endfunction

  task automatic modelReset();
    m_sl = 0; m_sr = 0; m_cl = 0; m_cr = 0; m_ec = 0;
    m_dl = 0; m_dr = 0; m_el = 0; m_er = 0;
  endtask

  task automatic modelEdge(input logic [2:0] pl, input logic [2:0] pr);
    int nl, nr;
    bit gl, gr;
    nl = steps(pl);
    nr = steps(pr);
    gl = isLegal(m_sl, nl, m_sr);
    gr = isLegal(m_sr, nr, m_sl);
    m_dl = gl && m_sl == 3 && nl == 0;
    m_dr = gr && m_sr == 3 && nr == 0;
    m_el = !gl;
    m_er = !gr;
    m_sl = (nl < 0) ? 0 : nl;
    m_sr = (nr < 0) ? 0 : nr;
    if (m_dl && m_cl < CNT_MAX) m_cl++;
    if (m_dr && m_cr < CNT_MAX) m_cr++;
    m_ec = m_ec + int'(m_el) + int'(m_er);
    if (m_ec > CNT_MAX) m_ec = CNT_MAX;
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, ".left_on"},      32'(left_on),      32'(m_sl != 0));
    checkOutput({ctx, ".right_on"},     32'(right_on),     32'(m_sr != 0));
    checkOutput({ctx, ".left_done"},    32'(left_done),    32'(m_dl));
    checkOutput({ctx, ".right_done"},   32'(right_done),   32'(m_dr));
    checkOutput({ctx, ".err_l"},        32'(err_l),        32'(m_el));
    checkOutput({ctx, ".err_r"},        32'(err_r),        32'(m_er));
    checkOutput({ctx, ".left_sweeps"},  32'(left_sweeps),  32'(m_cl));
    checkOutput({ctx, ".right_sweeps"}, 32'(right_sweeps), 32'(m_cr));
`ifdef LIGHTS_DECODER_ERRCNT_EN
    checkOutput({ctx, ".err_count"},    32'(err_count),    32'(m_ec));
`endif
  endtask

  task automatic applyStimulus(input logic [2:0] pl, input logic [2:0] pr, input string ctx);
    @(negedge clk);
    {la, lb, lc} = pl;
    {ra, rb, rc} = pr;
    @(posedge clk);
    modelEdge(pl, pr);
    #1;
    checkAll(ctx);
  endtask

  // Asynchronous reset between edges; outputs must clear before any clock edge.
  task automatic applyReset(input string ctx);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll(ctx);
    {la, lb, lc, ra, rb, rc} = 6'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [2:0] pickPattern(input int s);
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) begin
      if (s == 0) return ($urandom_range(0, 1) == 1) ? 3'b100 : 3'b000;
      case ((s + 1) % 4)
        1:       return 3'b100;
        2:       return 3'b110;
        3:       return 3'b111;
        default: return 3'b000;
      endcase
    end
    return 3'($urandom_range(0, 7));
  endfunction

  initial begin
    reset = 1'b0;
    {la, lb, lc, ra, rb, rc} = 6'b0;
    modelReset();
    #12;
    checkAll("reset");
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(3'b000, 3'b000, "idle");

    applyStimulus(3'b100, 3'b000, "left_p1");
    applyStimulus(3'b110, 3'b000, "left_p2");
    applyStimulus(3'b111, 3'b000, "left_p3");
    applyStimulus(3'b000, 3'b000, "left_end");

    applyStimulus(3'b100, 3'b100, "both_p1");
    applyStimulus(3'b110, 3'b110, "both_p2");
    applyStimulus(3'b111, 3'b111, "both_p3");
    applyStimulus(3'b000, 3'b000, "both_end");

    applyStimulus(3'b100, 3'b000, "mid_p1");
    applyStimulus(3'b110, 3'b100, "mid_rstart");
    applyStimulus(3'b111, 3'b110, "mid_adv");
    applyStimulus(3'b000, 3'b111, "mid_ldone");
    applyStimulus(3'b000, 3'b000, "mid_rdone");

    applyStimulus(3'b010, 3'b000, "bad_enc");
    applyStimulus(3'b100, 3'b000, "hold_a");
    applyStimulus(3'b100, 3'b000, "hold_b");
    applyStimulus(3'b010, 3'b010, "both_bad");
    applyStimulus(3'b110, 3'b111, "late_start");
    applyStimulus(3'b000, 3'b000, "recover");

    for (int k = 0; k < 9; k++) begin
      applyStimulus(3'b100, 3'b000, "sat_p1");
      applyStimulus(3'b110, 3'b000, "sat_p2");
      applyStimulus(3'b111, 3'b000, "sat_p3");
      applyStimulus(3'b000, 3'b000, "sat_end");
    end
    applyStimulus(3'b100, 3'b000, "pre_rst1");
    applyStimulus(3'b110, 3'b000, "pre_rst2");
    applyReset("async_rst");
    applyStimulus(3'b111, 3'b000, "post_rst");
    applyStimulus(3'b000, 3'b000, "post_rst2");

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        applyReset("rnd_rst");
      end else begin
        applyStimulus(pickPattern(m_sl), pickPattern(m_sr), "rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lights_decoder.md
Name: lights_decoder

Overview:
- Observer and decoder for the six-lamp tail-light pattern (la, lb, lc, ra, rb, rc) driven by the turn-signal light FSM.
- Samples the lamp bus every clock and reconstructs each half's sweep phase.
- Flags illegal patterns and illegal transitions, and counts completed left and right sweeps.
- Sits on the same clock as the light FSM. Used as an on-chip checker and as the receive end for a remote lamp display.

Parameters:
CNT_W, 8, width of each saturating sweep counter (and of the error counter when enabled); legal range 2..16.

Ports:
clk  input  1  rising-edge clock, same clock as the light FSM
reset  input  1  asynchronous, active-low reset (0 = in reset); async assert, release synchronised externally
la, lb, lc  input  1 each  left lamps, inner to outer
ra, rb, rc  input  1 each  right lamps, inner to outer
left_on  output  1  left tracker not idle
right_on  output  1  right tracker not idle
left_done  output  1  one-cycle pulse: legal left sweep completed
right_done  output  1  one-cycle pulse: legal right sweep completed
err_l  output  1  one-cycle pulse: illegal left pattern or transition
err_r  output  1  one-cycle pulse: illegal right pattern or transition
left_sweeps  output  CNT_W  saturating count of left_done pulses
right_sweeps  output  CNT_W  saturating count of right_done pulses

Behaviour:
- Per-half pattern notation: {a,b,c}, e.g. {la,lb,lc}.
- Legal encodings: IDLE=000, P1=100, P2=110, P3=111. Any other value (010, 001, 011, 101) is an illegal encoding.
- Each half has a registered tracker Q_h (2-bit phase: IDLE/P1/P2/P3). Reset value is IDLE.
- At each rising edge, sample P_h and check it against Q_L and Q_R.
- Legal transitions:
  - IDLE->IDLE always.
  - IDLE->P1 only if both Q_L and Q_R are IDLE. Both halves may start on the same edge (hazard/both case).
  - P1->P2, P2->P3, P3->IDLE.
- Everything else is illegal. This includes a hold in P1/P2/P3 (the sequence always advances), skips, backward steps, and IDLE->P1 while the other half is non-idle.
- Legal transition: Q_h <= P_h.
- P3->IDLE: additionally pulse h_done and increment h_sweeps, saturating at 2^CNT_W-1 with no wrap.
- Illegal transition or encoding:
  - Pulse err_h for one cycle.
  - Resync: Q_h <= P_h if P_h is a legal encoding, else IDLE.
  - No done pulse and no count change.
- The two halves are evaluated independently on the same edge. Both err_l and err_r, or both done pulses, may assert together.
- left_on = (Q_L != IDLE); right_on = (Q_R != IDLE).
- All outputs are registered: latency is 1 edge from the sampled pattern to the outputs.
- Pulses last exactly one cycle unless the next edge re-triggers them.
- Reset asserted (0), at any time including mid-sweep: all trackers IDLE; all pulses, flags and counters 0, asynchronously.
- After release, the first sampled non-idle pattern is judged against IDLE. 100 is legal; 110 and 111 are errors and the tracker resyncs to them.

Optional Feature:
- Macro LIGHTS_DECODER_ERRCNT_EN.
- Defined:
  - Adds output err_count [CNT_W-1:0], cleared by reset.
  - Increments by 1 for each edge with err_l or err_r set, and by 2 when both are set.
  - Saturates at 2^CNT_W-1.
- Undefined:
  - The port and its logic are absent.
  - All other behaviour is identical.

Test Plan:
- Reset with reset=0 and lamps at 000000, then release -> all outputs 0; left_sweeps=right_sweeps=0.
- Left sequence 100000,110000,111000,000000 on consecutive edges -> left_on=1 for 3 cycles; left_done pulses 1 cycle after the 000000 sample; left_sweeps=1; no err.
- Both-start sequence 100100,110110,111111,000000 -> left_done and right_done pulse on the same cycle; both counters =1; no err.
- Start right mid-left: 100000, then 110100 -> err_r=1 with Q_R resynced to P1, left_on=1, err_l=0. Then 111110 -> no err; left advances to P3 and right to P2.
- Illegal encoding 010000 from IDLE -> err_l pulse; left_on=0; left_sweeps unchanged. Hold 100000 for two edges -> err_l on the second edge.
- CNT_W=2: 5 legal left sweeps -> left_sweeps saturates at 3. Reset asserted mid-sweep -> counters 0 and left_on=0 immediately, without waiting for a clk edge.
- Errcnt build (LIGHTS_DECODER_ERRCNT_EN defined): an edge with illegal patterns on both halves (010010) -> err_count=2.
